math_div: RTL and testbench

- Iterative signed integer divider; the inverse of the combinational `math` multiplier (9-bit signed × 12-bit signed → 12-bit product).
- Recovers a quotient and remainder for game/physics code, e.g. position/velocity scaling, without a large combinational array.
- Sits beside `math` on the SoC's arithmetic peripheral. Driven by a start/done handshake from the CPU bus wrapper.
- One restoring-division step per clock.

---
 rtl/math_pkg.sv | 17 +
 rtl/math_div_step.sv | 30 +++
 rtl/math_div.sv | 125 ++++++++++++
 tb/tb_math_div.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// Shared arithmetic-peripheral definitions.
// Holds the default operand widths used by both the multiplier (math) and the
// divider (math_div) so their operands stay matched, plus the divider FSM states.
package math_pkg;

  // Dividend / quotient width (signed two's complement).
  localparam int unsigned DwDefault = 12;
  // Divisor / remainder width (signed two's complement).
  localparam int unsigned VwDefault = 9;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

endpackage

// File: rtl/math_div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem_in  - partial remainder magnitude before this step
//   bit_in  - next dividend bit (MSB first) shifted into the remainder
//   dvs     - divisor magnitude
//   rem_out - partial remainder after shift / trial subtract / restore
//   q_bit   - quotient bit produced by this step
module math_div_step #(
  parameter int unsigned VW = 9
) (
  input  logic [VW-1:0] rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] dvs,
  output logic [VW-1:0] rem_out,
  output logic          q_bit
);

  logic [VW:0]   shifted;
  logic [VW+1:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    // One extra bit so the MSB of diff is a true borrow.
    diff    = {1'b0, shifted} - {2'b00, dvs};
    q_bit   = ~diff[VW+1];
    // rem_in < dvs keeps both candidates below 2^VW.
    rem_out = q_bit ? diff[VW-1:0] : shifted[VW-1:0];
  end

endmodule

// File: rtl/math_div.sv
// Iterative signed integer divider, one restoring step per clock.
// Quotient truncates toward zero; remainder takes the dividend's sign.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   start          - request, sampled only while idle
//   dividend       - DW-bit signed dividend, captured on the accepted start
//   divisor        - VW-bit signed divisor, captured on the accepted start
//   busy           - high from the cycle after an accepted start until done
//   done           - one-cycle pulse; results valid from this cycle on
//   quotient       - DW-bit signed quotient, held until the next done
//   remainder      - VW-bit signed remainder, held until the next done
//   div_by_zero    - set with done when the divisor was zero
module math_div
  import math_pkg::*;
#(
  parameter int unsigned DW = DwDefault,
  parameter int unsigned VW = VwDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [DW-1:0] dividend,
  input  logic signed [VW-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] quotient,
  output logic signed [VW-1:0] remainder,
  output logic                 div_by_zero
);

  localparam int unsigned CW = $clog2(DW);

  state_e        state;
  // dvd_q shifts out dividend bits at the top and collects quotient bits at the bottom.
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [VW-1:0] rem_q;
  logic [CW-1:0] cnt_q;
  logic          q_neg_q;
  logic          r_neg_q;
  logic          dz_q;

  logic [DW-1:0] dvd_abs;
  logic [VW-1:0] dvs_abs;
  logic [VW-1:0] rem_step;
  logic          q_bit;

  // -(-2^(DW-1)) wraps to 2^(DW-1), which is exactly right as an unsigned magnitude.
  assign dvd_abs = dividend[DW-1] ? -dividend : dividend;
  assign dvs_abs = divisor[VW-1]  ? -divisor  : divisor;

  math_div_step #(
    .VW (VW)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[DW-1]),
    .dvs     (dvs_q),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd_q   <= dvd_abs;
            dvs_q   <= dvs_abs;
            rem_q   <= '0;
            cnt_q   <= CW'(DW - 1);
            q_neg_q <= dividend[DW-1] ^ divisor[VW-1];
            r_neg_q <= dividend[DW-1];
            busy    <= 1'b1;
            if (divisor == '0) begin
              dz_q  <= 1'b1;
              state <= FIX;
            end else begin
              dz_q  <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_step;
          dvd_q <= {dvd_q[DW-2:0], q_bit};
          if (cnt_q == '0) begin
            state <= FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          if (dz_q) begin
            quotient  <= '1;
            remainder <= '0;
          end else begin
            quotient  <= q_neg_q ? -dvd_q : dvd_q;
            remainder <= r_neg_q ? -rem_q : rem_q;
          end
          div_by_zero <= dz_q;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_math_div.sv
// Self-checking bench for math_div: directed cases plus randomized operands
// compared against an integer-arithmetic reference model.
module tb_math_div;

  localparam int DW = 12;
  localparam int VW = 9;
  localparam int QMASK = (1 << DW) - 1;
  localparam int RMASK = (1 << VW) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic signed [DW-1:0] dividend;
  logic signed [VW-1:0] divisor;
  logic                 busy;
  logic                 done;
  logic signed [DW-1:0] quotient;
  logic signed [VW-1:0] remainder;
  logic                 div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;
  int last_q   = 0;

  always #5 clk = ~clk;

  math_div #(
    .DW (DW),
    .VW (VW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Truncating signed division; results masked to the port widths by the caller.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int dz);
    if (b == 0) begin
      q = -1; r = 0; dz = 1;
    end else begin
      q = a / b; r = a % b; dz = 0;
    end
  endfunction

  // Call at a negedge. ignore_at > 0 pulses a competing start that many cycles in.
  task automatic run_div(input int a, input int b, input int ignore_at);
    int q, r, dz, lat, exp_lat;
    model(a, b, q, r, dz);
    // Accepting edge, then one FIX edge for zero divisors or DW CALC + FIX otherwise.
    exp_lat  = (b == 0) ? 1 : DW + 1;
    dividend = DW'(a);
    divisor  = VW'(b);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    check("busy_after_start", {31'd0, busy}, 1);
    check("hold_quotient", {20'd0, quotient}, last_q & QMASK);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!done && lat == ignore_at) begin
        start = 1'b1; dividend = 12'sd5; divisor = 9'sd1;
      end else begin
        start = 1'b0;
      end
    end
    check("done_seen", {31'd0, done}, 1);
    check("latency", lat, exp_lat);
    check("busy_at_done", {31'd0, busy}, 0);
    check("quotient", {20'd0, quotient}, q & QMASK);
    check("remainder", {23'd0, remainder}, r & RMASK);
    check("div_by_zero", {31'd0, div_by_zero}, dz);
    if (dz == 0) begin
      // Identity and bounds, independent of the model's division.
      check("identity", (int'(quotient) * b + int'(remainder)) & QMASK, a & QMASK);
      check("rem_bound", int'((remainder < 0 ? -int'(remainder) : int'(remainder)) <
                              (b < 0 ? -b : b)), 1);
      check("rem_sign", int'(remainder == 0 || ((remainder < 0) == (a < 0))), 1);
    end
    last_q = q;
  endtask

  initial begin
    int saw_done;
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_quotient", {20'd0, quotient}, 0);
    check("rst_remainder", {23'd0, remainder}, 0);
    check("rst_dz", {31'd0, div_by_zero}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_div(2047, 255, 0);
    check("t1_q_const", {20'd0, quotient}, 8);
    check("t1_r_const", {23'd0, remainder}, 7);
    run_div(-2047, 255, 0);
    check("t2_q_const", {20'd0, quotient}, 'hFF8);
    check("t2_r_const", {23'd0, remainder}, 'h1F9);
    run_div(2047, -255, 0);
    run_div(-2048, -1, 0);
    check("t3_overflow", {20'd0, quotient}, 'h800);
    run_div(-2048, -256, 0);
    run_div(100, 0, 0);
    check("t4_dz_q", {20'd0, quotient}, 'hFFF);
    run_div(1000, 7, 4);
    check("t5_ignore_q", {20'd0, quotient}, 142);
    // Start on the done cycle must be accepted.
    run_div(-1000, 7, 0);
    run_div(300, -13, 0);

    // Reset mid-operation aborts and clears everything.
    @(negedge clk);
    dividend = 12'sd1500; divisor = 9'sd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_quotient", {20'd0, quotient}, 0);
    check("abort_remainder", {23'd0, remainder}, 0);
    check("abort_dz", {31'd0, div_by_zero}, 0);
    saw_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("abort_no_done", saw_done, 0);
    last_q = 0;

    // Randomized operands, a few zero divisors included.
    for (int i = 0; i < 2000; i++) begin
      ra = DW'($urandom);
      rb = ($urandom_range(0, 31) == 0) ? '0 : VW'($urandom);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_div(int'($signed(ra)), int'($signed(rb)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
